// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control sequencer: steps each instruction through IF/ID/EX/MEM/WB.
// Define PERF_COUNTERS_EN to build the retired-instruction and active-cycle counters.
module multicycle_control_fsm #(
    parameter int CNT_W = 32,
    parameter int OPC_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ack,
    output logic [2:0]       sel,
    output logic             Reg_Write,
    output logic             mem_req,
    output logic             mem_we,
    output logic             IR_Write,
    output logic             PC_Write,
    output logic             PC_Write_Cond,
    output logic             ALU_Src,
    output logic [1:0]       ALU_Op,
    output logic             Mem_to_Reg,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(7'b0110011);
    localparam logic [OPC_W-1:0] OP_I    = OPC_W'(7'b0010011);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(7'b0000011);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(7'b0100011);
    localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(7'b1100011);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(7'b0000000);

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LD, C_ST, C_BR, C_HALT, C_BAD
    } cls_t;

    state_t state;
    state_t state_nx;
    cls_t   cls;
    cls_t   cls_nx;

    function automatic cls_t classify(input logic [OPC_W-1:0] op);
        cls_t c;
        case (op)
            OP_R:    c = C_R;
            OP_I:    c = C_I;
            OP_LD:   c = C_LD;
            OP_ST:   c = C_ST;
            OP_BR:   c = C_BR;
            OP_HALT: c = C_HALT;
            default: c = C_BAD;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] sel_of(input state_t s);
        logic [2:0] v;
        case (s)
            S_IF:    v = 3'd0;
            S_ID:    v = 3'd1;
            S_EX:    v = 3'd2;
            S_MEM:   v = 3'd3;
            S_WB:    v = 3'd4;
            default: v = 3'd7;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] alu_op_of(input cls_t c);
        logic [1:0] v;
        case (c)
            C_BR:     v = 2'b01;
            C_R, C_I: v = 2'b10;
            default:  v = 2'b00;
        endcase
        return v;
    endfunction

    // Memory handshake: mem_req stays high in IF/MEM until a one-cycle mem_ack;
    // an ack arriving while mem_req is low has no effect.
    always_comb begin
        state_nx = state;
        cls_nx   = cls;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_IF;
            end
            S_IF: begin
                if (mem_ack) state_nx = S_ID;
            end
            S_ID: begin
                cls_nx = classify(opcode);
                case (cls_nx)
                    C_R, C_I, C_LD, C_ST, C_BR: state_nx = S_EX;
                    C_HALT:                     state_nx = S_HALT;
                    default:                    state_nx = S_IF;
                endcase
            end
            S_EX: begin
                case (cls)
                    C_LD, C_ST: state_nx = S_MEM;
                    C_BR:       state_nx = S_IF;
                    default:    state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ack) state_nx = (cls == C_ST) ? S_IF : S_WB;
            end
            S_WB: begin
                state_nx = S_IF;
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so they line up with the
    // state register exactly as a Moore decode would.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cls           <= C_R;
            sel           <= 3'd7;
            Reg_Write     <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            PC_Write      <= 1'b0;
            PC_Write_Cond <= 1'b0;
            ALU_Src       <= 1'b0;
            ALU_Op        <= 2'b00;
            Mem_to_Reg    <= 1'b0;
            illegal       <= 1'b0;
            halted        <= 1'b0;
        end else begin
            state         <= state_nx;
            cls           <= cls_nx;
            sel           <= sel_of(state_nx);
            Reg_Write     <= (state_nx == S_WB);
            mem_req       <= (state_nx == S_IF) || (state_nx == S_MEM);
            mem_we        <= (state_nx == S_MEM) && (cls_nx == C_ST);
            PC_Write      <= (state_nx == S_ID);
            PC_Write_Cond <= (state_nx == S_EX) && (cls_nx == C_BR);
            ALU_Src       <= (state_nx == S_EX) && (cls_nx inside {C_I, C_LD, C_ST});
            ALU_Op        <= (state_nx == S_EX) ? alu_op_of(cls_nx) : 2'b00;
            Mem_to_Reg    <= (state_nx == S_WB) && (cls_nx == C_LD);
            halted        <= (state_nx == S_HALT);
            if (state == S_ID && cls_nx == C_BAD) illegal <= 1'b1;
        end
    end

    // The fetched word must be captured in the same cycle the ack arrives.
    assign IR_Write = (state == S_IF) && mem_ack;

`ifdef PERF_COUNTERS_EN
    logic retire;
    logic active;

    assign retire = (state == S_WB)
                 || (state == S_EX && cls == C_BR)
                 || (state == S_MEM && cls == C_ST && mem_ack);
    assign active = (state inside {S_IF, S_ID, S_EX, S_MEM, S_WB});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
            cycle_cnt   <= '0;
        end else begin
            if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
            if (active) cycle_cnt   <= cycle_cnt + CNT_W'(1);
        end
    end
`else
    assign retired_cnt = '0;
    assign cycle_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level model expands each instruction
// into its per-cycle stage list and predicts every control output for each cycle.
module tb_multicycle_control_fsm;

    localparam int CNT_W = 4;
    localparam int OPC_W = 7;
    localparam int EW    = 15 + 2 * CNT_W;
`ifdef PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_HALT = 5, C_BAD = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [OPC_W-1:0] opcode;
    logic             mem_ack;
    logic [2:0]       sel;
    logic             Reg_Write, mem_req, mem_we, IR_Write, PC_Write, PC_Write_Cond, ALU_Src;
    logic [1:0]       ALU_Op;
    logic             Mem_to_Reg, illegal, halted;
    logic [CNT_W-1:0] retired_cnt, cycle_cnt;

    multicycle_control_fsm #(.CNT_W(CNT_W), .OPC_W(OPC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ack(mem_ack),
        .sel(sel), .Reg_Write(Reg_Write), .mem_req(mem_req), .mem_we(mem_we),
        .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond),
        .ALU_Src(ALU_Src), .ALU_Op(ALU_Op), .Mem_to_Reg(Mem_to_Reg),
        .illegal(illegal), .halted(halted),
        .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // scoreboard state and model
    logic [EW-1:0]    exp_q[$];
    int               n_total = 0;
    int               n_bad   = 0;
    logic             m_ill, m_halt;
    logic [CNT_W-1:0] m_ret, m_cyc;
    int               sel_seen[$];
    logic [CNT_W-1:0] ret_first;
    logic [EW-1:0]    act;
    logic [EW-1:0]    reset_vec;

    assign act = {sel, Reg_Write, mem_req, mem_we, IR_Write, PC_Write, PC_Write_Cond,
                  ALU_Src, ALU_Op, Mem_to_Reg, illegal, halted, retired_cnt, cycle_cnt};

    function automatic logic [6:0] opc_of(input int c);
        case (c)
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_LD:    return 7'b0000011;
            C_ST:    return 7'b0100011;
            C_BR:    return 7'b1100011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] rand_bad();
        logic [6:0] o;
        do begin
            o = 7'($urandom_range(1, 127));
        end while (o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 || o == 7'h63);
        return o;
    endfunction

    // stage: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB, 7 IDLE/HALT
    function automatic logic [EW-1:0] expv(input int stage, input int c, input logic ack);
        logic [1:0]       aop;
        logic [CNT_W-1:0] r, cy;
        aop = 2'b00;
        if (stage == 2) begin
            if (c == C_BR) aop = 2'b01;
            else if (c == C_R || c == C_I) aop = 2'b10;
        end
        r  = PERF ? m_ret : '0;
        cy = PERF ? m_cyc : '0;
        return {3'(stage), stage == 4, (stage == 0 || stage == 3), (stage == 3 && c == C_ST),
                (stage == 0 && ack), stage == 1, (stage == 2 && c == C_BR),
                (stage == 2 && (c == C_I || c == C_LD || c == C_ST)), aop,
                (stage == 4 && c == C_LD), m_ill, m_halt, r, cy};
    endfunction

    always @(negedge clk) begin : compare
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, act, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // driver tasks
    task automatic step(input logic s, input logic a, input logic [6:0] op, input logic [EW-1:0] e);
        @(posedge clk);
        #1;
        start   = s;
        mem_ack = a;
        opcode  = op;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_ill  = 1'b0;
        m_halt = 1'b0;
        m_ret  = '0;
        m_cyc  = '0;
    endtask

    task automatic idle_cycle(input logic s);
        step(s, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), expv(7, C_R, 1'b0));
    endtask

    task automatic halt_cycle();
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
             expv(7, C_R, 1'b0));
    endtask

    // cut > 0 stops after that many cycles, leaving the instruction in flight
    task automatic run_instr(input int c, input int if_wait, input int mem_wait, input int cut);
        int         st[$];
        logic [6:0] opc;
        logic       a;
        int         n;
        sel_seen = {};
        repeat (if_wait + 1) st.push_back(0);
        st.push_back(1);
        if (c == C_R || c == C_I) begin
            st.push_back(2); st.push_back(4);
        end else if (c == C_LD) begin
            st.push_back(2); repeat (mem_wait + 1) st.push_back(3); st.push_back(4);
        end else if (c == C_ST) begin
            st.push_back(2); repeat (mem_wait + 1) st.push_back(3);
        end else if (c == C_BR) begin
            st.push_back(2);
        end
        opc = (c == C_BAD) ? rand_bad() : opc_of(c);
        n = (cut > 0) ? cut : st.size();
        for (int i = 0; i < n; i++) begin
            if (st[i] == 0 || st[i] == 3) a = (i + 1 == st.size()) || (st[i + 1] != st[i]);
            else a = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), a, (st[i] == 0) ? 7'($urandom_range(0, 127)) : opc,
                 expv(st[i], c, a));
            #3;
            sel_seen.push_back(int'(sel));
            if (i == 0) ret_first = retired_cnt;
            m_cyc++;
            if (st[i] == 1 && c == C_BAD) m_ill = 1'b1;
        end
        if (n == st.size()) begin
            if (c <= C_BR) m_ret++;
            if (c == C_HALT) m_halt = 1'b1;
        end
    endtask

    // called 4 time units after a rising edge; reset lands mid-cycle
    task automatic async_reset_check(input string name);
        #3;
        rst = 1'b1;
        #1;
        check(name, 32'(act), 32'(reset_vec));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [11:0] seq;
        int          c;
        reset_vec = '0;
        reset_vec[EW-1 -: 3] = 3'b111;
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; opcode = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(act), 32'(reset_vec));
        rst = 1'b0;

        // idle holds with start low, then an R instruction with immediate acks
        repeat (5) idle_cycle(1'b0);
        idle_cycle(1'b1);
        run_instr(C_R, 0, 0, 0);
        seq = {3'(sel_seen[0]), 3'(sel_seen[1]), 3'(sel_seen[2]), 3'(sel_seen[3])};
        check("r_sel_sequence", 32'(seq), 32'h054);
        check("r_length", 32'(sel_seen.size()), 32'd4);

        run_instr(C_LD, 0, 3, 0);
        check("retired_after_r", 32'(ret_first), PERF ? 32'd1 : 32'd0);
        check("ld_delayed_length", 32'(sel_seen.size()), 32'd8);
        run_instr(C_ST, 0, 0, 0);
        check("st_length", 32'(sel_seen.size()), 32'd4);
        run_instr(C_BR, 0, 0, 0);
        check("br_length", 32'(sel_seen.size()), 32'd3);
        run_instr(C_I, 2, 0, 0);
        check("i_fetch_wait_length", 32'(sel_seen.size()), 32'd6);

        run_instr(C_BAD, 1, 0, 0);
        check("bad_length", 32'(sel_seen.size()), 32'd3);
        run_instr(C_R, 0, 0, 0);
        check("illegal_sticky", 32'(illegal), 32'd1);

        run_instr(C_HALT, 0, 0, 0);
        repeat (6) halt_cycle();
        #3;
        check("halted_flag", 32'(halted), 32'd1);
        check("halted_sel", 32'(sel), 32'd7);

        // reset during WB of an R instruction
        async_reset_check("reset_from_halt");
        idle_cycle(1'b1);
        run_instr(C_R, 0, 0, 4);
        check("wb_reached", 32'(sel_seen[3]), 32'd4);
        async_reset_check("reset_in_wb");

        // sixteen retirements wrap a 4-bit counter
        idle_cycle(1'b1);
        repeat (16) run_instr(C_BR, 0, 0, 0);
        run_instr(C_R, 0, 0, 0);
        check("retired_wrap", 32'(ret_first), 32'd0);

        // randomized instruction mix
        async_reset_check("reset_before_random");
        repeat ($urandom_range(0, 3)) idle_cycle(1'b0);
        idle_cycle(1'b1);
        for (int k = 0; k < 80; k++) begin
            c = ($urandom_range(0, 9) == 0) ? C_BAD : int'($urandom_range(0, 4));
            run_instr(c, $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end
        run_instr(C_HALT, $urandom_range(0, 2), 0, 0);
        repeat (4) halt_cycle();

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
